tdc_frame_ctrl: RTL and testbench
=================================

# tdc_frame_ctrl

Frame sequencer for the SPAD/TDC front end. Each frame it asserts the TDC start, holds a fixed acquisition window in clk_250M cycles, and timestamps up to MAX_HITS photon hits from the SPAD time-gate strobe, capturing the SPAD intensity word for each hit. It then presents the frame result on a valid/ready handshake and enforces a dead time, with clear asserted, before re-arming. It sits between the SPAD front end and the histogram/readout logic.

## Interface
- RANGE_CYC, 512: acquisition window length in cycles (2048 ns at 250 MHz); 2..2^TS_W
- DEAD_CYC, 16: dead-time cycles after result accepted; ≥1
- MAX_HITS, 3: hit slots per frame; 1..3
- TS_W, 9: timestamp width
- INT_W, 16: intensity width
- clk_250M  in  1  system clock
- rst_auto  in  1  reset, asynchronous, active-high
- en  in  1  frame enable, sampled in IDLE
- time_gate_in  in  1  hit strobe from SPAD, asynchronous, ≥1 cycle wide (upstream stretch)
- spad_int_in  in  INT_W  SPAD intensity, stable from strobe until clear
- tdc_start  out  1  high for the whole ACQ window
- frame_clr  out  1  high during DEAD; drives SPAD/TDC clear
- res_valid  out  1  frame result valid
- res_ready  in  1  consumer accepts result
- res_nhits  out  2  hits captured (0..MAX_HITS)
- res_ovf  out  1  more than MAX_HITS hits seen in window
- res_ts  out  3*TS_W  packed timestamps, slot 0 in LSBs
- res_int  out  3*INT_W  packed intensities, slot 0 in LSBs
- drop_cnt  out  8  saturating count of hits outside ACQ

## Operation
- time_gate_in passes through a 2-FF synchronizer; a hit is the rising edge of the synchronized signal (one-cycle hit pulse).
- States: IDLE, ARM, ACQ, DONE, DEAD.
- IDLE: if en=1, go to ARM; otherwise stay.
- ARM (1 cycle): clear the slots, nhits, ovf and cycle counter; go to ACQ.
- ACQ: tdc_start=1 and the counter increments from 0. On a hit with nhits<MAX_HITS: slot[nhits].ts ← counter, slot[nhits].int ← spad_int_in, nhits++. On a hit with nhits=MAX_HITS: ovf←1. After the cycle with counter=RANGE_CYC-1, go to DONE. A hit on that last cycle is captured.
- DONE: res_valid=1 and the result is held stable. On res_valid&res_ready, go to DEAD.
- DEAD: frame_clr=1 for DEAD_CYC cycles, then go to IDLE.
- A hit in IDLE, ARM, DONE or DEAD increments drop_cnt, which saturates at 255. drop_cnt is cleared only by reset.
- Unused slots read 0.
- Timestamps carry the 2-cycle synchronizer latency, uncompensated. Downstream subtracts it.

## Timing
- Reset (async assert, sync release): state=IDLE; tdc_start=0, frame_clr=0, res_valid=0, res_nhits=0, res_ovf=0, res_ts=0, res_int=0, drop_cnt=0; synchronizer flops=0.
- en=1 in IDLE → ARM next cycle → tdc_start rises 2 cycles after IDLE samples en.
- tdc_start is high for exactly RANGE_CYC cycles.
- res_valid rises the cycle after the last ACQ cycle. It falls the cycle after the handshake. Back-to-back is not possible because DEAD intervenes.
- Frame period with res_ready held at 1 is 1+1+RANGE_CYC+1+DEAD_CYC cycles.
- rst_auto asserted mid-frame aborts immediately; no partial result is emitted.
- en deasserted during a frame has no effect until the frame returns to IDLE.

## Configuration
- TDC_FRAME_EARLY_END_EN defined: ACQ ends the cycle after the MAX_HITS-th hit is captured; ovf can never be set.
- TDC_FRAME_EARLY_END_EN undefined: ACQ always runs the full RANGE_CYC cycles; ovf behaves as described in Operation.

## Test plan
- Reset, then en=1 with no hits → tdc_start high 512 cycles; res_nhits=0, res_ts=0, res_int=0; after handshake, frame_clr high 16 cycles.
- Hits whose synchronized edges land at counter 10, 100 and 511 with intensities 0x0005, 0x0007, 0x0009 → nhits=3, ts={511,100,10}, int={9,7,5}, ovf=0.
- Four hits in one window (macro undefined) → nhits=3, ovf=1, first three captured. Same stimulus with the macro defined → ACQ ends the cycle after the third hit, ovf=0.
- res_ready held low 50 cycles in DONE → res_valid and payload stable throughout; a hit during DONE gives drop_cnt=1 and the result is unchanged.
- rst_auto pulsed at ACQ counter 200 → all outputs return to reset values asynchronously; with en=1 a new frame starts after release, with counter=0 at the first ACQ cycle.
- 300 hits injected during IDLE with en=0 → drop_cnt saturates at 255.

Source files
------------

// File: rtl/tdc_frame_ctrl.sv
// tdc_frame_ctrl: SPAD/TDC frame sequencer (arm, acquire, report, dead time).
// Optional TDC_FRAME_EARLY_END_EN: end ACQ right after the last hit slot fills.
module tdc_frame_ctrl #(
    parameter int RANGE_CYC = 512,
    parameter int DEAD_CYC  = 16,
    parameter int MAX_HITS  = 3,
    parameter int TS_W      = 9,
    parameter int INT_W     = 16
) (
    input  logic                 clk_250M,
    input  logic                 rst_auto,
    input  logic                 en,
    input  logic                 time_gate_in,
    input  logic [INT_W-1:0]     spad_int_in,
    output logic                 tdc_start,
    output logic                 frame_clr,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_nhits,
    output logic                 res_ovf,
    output logic [3*TS_W-1:0]    res_ts,
    output logic [3*INT_W-1:0]   res_int,
    output logic [7:0]           drop_cnt
);

    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DW-1:0]   DEAD_LAST = DW'(DEAD_CYC - 1);
    localparam logic [TS_W-1:0] ACQ_LAST  = TS_W'(RANGE_CYC - 1);
    localparam logic [1:0]      HIT_MAX   = 2'(MAX_HITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACQ,
        S_DONE,
        S_DEAD
    } state_t;

    state_t r_state;
    state_t w_next;

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    logic [TS_W-1:0] r_cnt;
    logic [DW-1:0]   r_dcnt;
    logic [1:0]      r_nhits;
    logic            r_ovf;
    logic [7:0]      r_drop;

    logic [2:0][TS_W-1:0]  r_ts;
    logic [2:0][INT_W-1:0] r_int;

    logic w_hit;
    logic w_in_acq;
    logic w_full;
    logic w_take;
    logic w_early;

    assign w_hit    = r_sync2 & ~r_sync3;
    assign w_in_acq = (r_state == S_ACQ);
    assign w_full   = (r_nhits == HIT_MAX);
    assign w_take   = w_hit & w_in_acq & ~w_full;

`ifdef TDC_FRAME_EARLY_END_EN
    assign w_early = w_take & (r_nhits == HIT_MAX - 2'd1);
`else
    assign w_early = 1'b0;
`endif

    // Synchronize the asynchronous gate strobe; third flop detects the edge.
    always_ff @(posedge clk_250M or posedge rst_auto) begin
        if (rst_auto) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= time_gate_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_250M or posedge rst_auto) begin
        if (rst_auto) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded strobes.
    always_comb begin
        w_next    = r_state;
        tdc_start = 1'b0;
        frame_clr = 1'b0;
        res_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_next = S_ARM;
                end
            end
            S_ARM: begin
                w_next = S_ACQ;
            end
            S_ACQ: begin
                tdc_start = 1'b1;
                if (r_cnt == ACQ_LAST || w_early) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_DEAD;
                end
            end
            S_DEAD: begin
                frame_clr = 1'b1;
                if (r_dcnt == DEAD_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Window counter, dead counter and hit slot capture.
    always_ff @(posedge clk_250M or posedge rst_auto) begin
        if (rst_auto) begin
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_nhits <= '0;
            r_ovf   <= 1'b0;
            r_ts    <= '0;
            r_int   <= '0;
        end else begin
            if (r_state == S_DEAD) begin
                r_dcnt <= r_dcnt + 1'b1;
            end else begin
                r_dcnt <= '0;
            end
            if (r_state == S_ARM) begin
                r_cnt   <= '0;
                r_nhits <= '0;
                r_ovf   <= 1'b0;
                r_ts    <= '0;
                r_int   <= '0;
            end else if (w_in_acq) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_take) begin
                    for (int i = 0; i < 3; i++) begin
                        if (r_nhits == 2'(i)) begin
                            r_ts[i]  <= r_cnt;
                            r_int[i] <= spad_int_in;
                        end
                    end
                    r_nhits <= r_nhits + 2'd1;
                end
`ifndef TDC_FRAME_EARLY_END_EN
                if (w_hit && w_full) begin
                    r_ovf <= 1'b1;
                end
`endif
            end
        end
    end

    // Saturating count of hits that arrive outside the window.
    always_ff @(posedge clk_250M or posedge rst_auto) begin
        if (rst_auto) begin
            r_drop <= '0;
        end else if (w_hit && !w_in_acq && r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign res_nhits = r_nhits;
    assign res_ovf   = r_ovf;
    assign res_ts    = r_ts;
    assign res_int   = r_int;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_tdc_frame_ctrl.sv
// tb_tdc_frame_ctrl: directed bench for tdc_frame_ctrl.
// Hits are scheduled by the window counter value they should land on.
module tb_tdc_frame_ctrl;

    logic        clk_250M = 1'b0;
    logic        rst_auto;
    logic        en;
    logic        time_gate_in;
    logic [15:0] spad_int_in;
    logic        tdc_start;
    logic        frame_clr;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_nhits;
    logic        res_ovf;
    logic [26:0] res_ts;
    logic [47:0] res_int;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int          tg[4];
    logic [15:0] iv[4];
    int          ntg;
    int          ncyc;

    tdc_frame_ctrl dut (
        .clk_250M     (clk_250M),
        .rst_auto     (rst_auto),
        .en           (en),
        .time_gate_in (time_gate_in),
        .spad_int_in  (spad_int_in),
        .tdc_start    (tdc_start),
        .frame_clr    (frame_clr),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_nhits    (res_nhits),
        .res_ovf      (res_ovf),
        .res_ts       (res_ts),
        .res_int      (res_int),
        .drop_cnt     (drop_cnt)
    );

    always #2 clk_250M = ~clk_250M;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; leaves at the first ACQ negedge.
    task automatic start_frame();
        int lat;
        lat = 0;
        en = 1'b1;
        do begin
            @(negedge clk_250M);
            lat++;
        end while (!tdc_start && lat < 10);
        chk("start_lat", 64'(lat), 64'd2);
        en = 1'b0;
    endtask

    // Drives scheduled gate pulses; returns the number of ACQ cycles.
    task automatic run_acq(output int n);
        logic g;
        n = 0;
        while (tdc_start && n < 2000) begin
            g = 1'b0;
            for (int k = 0; k < ntg; k++) begin
                if (n >= tg[k] - 2 && n < tg[k]) begin
                    g = 1'b1;
                    spad_int_in = iv[k];
                end
            end
            time_gate_in = g;
            @(negedge clk_250M);
            n++;
        end
        time_gate_in = 1'b0;
    endtask

    // Handshake from DONE, then measure the dead time.
    task automatic finish_frame();
        int n;
        res_ready = 1'b1;
        @(negedge clk_250M);
        res_ready = 1'b0;
        chk("hs_valid_fall", 64'(res_valid), 64'd0);
        n = 0;
        while (frame_clr && n < 100) begin
            n++;
            @(negedge clk_250M);
        end
        chk("dead_len", 64'(n), 64'd16);
        repeat (3) @(negedge clk_250M);
        chk("idle_after", 64'({tdc_start, res_valid}), 64'd0);
    endtask

    task automatic gate_pulses(input int cnt);
        for (int p = 0; p < cnt; p++) begin
            time_gate_in = 1'b1;
            repeat (2) @(negedge clk_250M);
            time_gate_in = 1'b0;
            repeat (2) @(negedge clk_250M);
        end
    endtask

    initial begin
        rst_auto     = 1'b1;
        en           = 1'b0;
        time_gate_in = 1'b0;
        spad_int_in  = '0;
        res_ready    = 1'b0;
        ntg          = 0;
        repeat (3) @(negedge clk_250M);
        chk("rst_ctl", 64'({tdc_start, frame_clr, res_valid}), 64'd0);
        chk("rst_nhits", 64'(res_nhits), 64'd0);
        chk("rst_ovf", 64'(res_ovf), 64'd0);
        chk("rst_ts", 64'(res_ts), 64'd0);
        chk("rst_int", 64'(res_int), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst_auto = 1'b0;
        repeat (3) @(negedge clk_250M);
        chk("idle_no_en", 64'(tdc_start), 64'd0);

        // Empty frame.
        ntg = 0;
        start_frame();
        run_acq(ncyc);
        chk("f1_len", 64'(ncyc), 64'd512);
        chk("f1_valid", 64'(res_valid), 64'd1);
        chk("f1_nhits", 64'(res_nhits), 64'd0);
        chk("f1_ts", 64'(res_ts), 64'd0);
        chk("f1_int", 64'(res_int), 64'd0);
        finish_frame();

        // Three hits including the last window cycle.
        ntg = 3;
        tg[0] = 10;  iv[0] = 16'h0005;
        tg[1] = 100; iv[1] = 16'h0007;
        tg[2] = 511; iv[2] = 16'h0009;
        start_frame();
        run_acq(ncyc);
        chk("f2_len", 64'(ncyc), 64'd512);
        chk("f2_nhits", 64'(res_nhits), 64'd3);
        chk("f2_ovf", 64'(res_ovf), 64'd0);
        chk("f2_ts", 64'(res_ts), 64'({9'd511, 9'd100, 9'd10}));
        chk("f2_int", 64'(res_int),
            64'({16'h0009, 16'h0007, 16'h0005}));
        finish_frame();

        // Four hits: overflow, or early end when configured.
        ntg = 4;
        tg[0] = 10;  iv[0] = 16'h0001;
        tg[1] = 100; iv[1] = 16'h0002;
        tg[2] = 200; iv[2] = 16'h0003;
        tg[3] = 300; iv[3] = 16'h0004;
        start_frame();
        run_acq(ncyc);
`ifdef TDC_FRAME_EARLY_END_EN
        chk("f3_len", 64'(ncyc), 64'd201);
        chk("f3_ovf", 64'(res_ovf), 64'd0);
`else
        chk("f3_len", 64'(ncyc), 64'd512);
        chk("f3_ovf", 64'(res_ovf), 64'd1);
`endif
        chk("f3_nhits", 64'(res_nhits), 64'd3);
        chk("f3_ts", 64'(res_ts), 64'({9'd200, 9'd100, 9'd10}));
        chk("f3_int", 64'(res_int),
            64'({16'h0003, 16'h0002, 16'h0001}));
        chk("f3_drop", 64'(drop_cnt), 64'd0);
        finish_frame();

        // One hit, then DONE held 50 cycles with a stray hit.
        ntg = 1;
        tg[0] = 50; iv[0] = 16'h1234;
        start_frame();
        run_acq(ncyc);
        for (int i = 0; i < 50; i++) begin
            if (i == 5) begin
                time_gate_in = 1'b1;
                spad_int_in  = 16'hFFFF;
            end
            if (i == 7) time_gate_in = 1'b0;
            chk("done_hold",
                64'({res_valid, res_nhits, res_ovf, res_ts}),
                64'({1'b1, 2'd1, 1'b0, 27'd50}));
            @(negedge clk_250M);
        end
        chk("f4_int", 64'(res_int), 64'h1234);
        chk("f4_drop", 64'(drop_cnt), 64'd1);
        finish_frame();

        // Reset in the middle of ACQ.
        ntg = 0;
        start_frame();
        repeat (200) @(negedge clk_250M);
        rst_auto = 1'b1;
        #1;
        chk("mrst_ctl", 64'({tdc_start, frame_clr, res_valid}), 64'd0);
        chk("mrst_drop", 64'(drop_cnt), 64'd0);
        chk("mrst_res", 64'({res_nhits, res_ovf}), 64'd0);
        @(negedge clk_250M);
        rst_auto = 1'b0;
        @(negedge clk_250M);
        ntg = 1;
        tg[0] = 10; iv[0] = 16'hABCD;
        start_frame();
        run_acq(ncyc);
        chk("f5_len", 64'(ncyc), 64'd512);
        chk("f5_nhits", 64'(res_nhits), 64'd1);
        chk("f5_ts", 64'(res_ts), 64'd10);
        chk("f5_int", 64'(res_int), 64'hABCD);
        finish_frame();

        // Drop counter saturation in IDLE.
        gate_pulses(100);
        chk("drop_100", 64'(drop_cnt), 64'd100);
        gate_pulses(200);
        chk("drop_sat", 64'(drop_cnt), 64'd255);
        chk("drop_idle", 64'(tdc_start), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
